output_dispatch_ctrl: RTL and testbench
=======================================

# output_dispatch_ctrl

Frame scheduler sitting between the upstream Gray-coding datapath and the 8-channel serializer output stage. Accepts frames (128-bit payload, target channel, bit length) over a valid/ready handshake and buffers them in a small pending queue. Issues each frame to its channel as a one-cycle `vld_ch` pulse with `data_gray`/`data_count`, only when that channel's serializer is idle. Tracks per-channel serializer occupancy internally, because the output stage exposes no busy signal.

## Interface
- `DEPTH`, 4: pending-queue entries (2..8).
- `MAX_LEN`, 128: largest legal frame length in bits (serializer shift width).

- `clk_out16x`  in  1  output-domain clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; clears all state.
- `in_valid`  in  1  upstream frame present.
- `in_ready`  out  1  queue can accept; equals queue not full.
- `in_data`  in  128  frame payload, MSB sent first.
- `in_ch`  in  3  target channel 0..7.
- `in_len`  in  16  frame length in bits.
- `data_gray`  out  128  payload to output stage, registered.
- `data_count`  out  16  length to output stage, registered.
- `vld_ch`  out  8  one-hot start pulse to output stage, registered.
- `busy_ch`  out  8  channel occupancy (counter nonzero).
- `pending`  out  4  current queue occupancy.
- `err_len`  out  1  one-cycle pulse on an illegal `in_len` at accept.

## Operation
- Accept occurs on an edge where `in_valid & in_ready`. `in_ready = (pending != DEPTH)`. There is no same-cycle bypass when full.
- Length rules at accept:
  - `in_len == 0`: frame dropped, not queued, `err_len` pulses.
  - `in_len > MAX_LEN`: length clamped to `MAX_LEN`, queued, `err_len` pulses.
  - Otherwise the frame is queued unchanged.
- Queue is oldest-first and held in age order. Each entry holds {data, ch, len}. On removal, younger entries shift down.
- Per-channel 16-bit occupancy counter `occ[c]`:
  - On dispatch to c, `occ[c]` loads the dispatched len.
  - Otherwise it decrements while nonzero.
  - Channel c is eligible iff `occ[c] == 0`.
- Dispatch selection (each cycle): pick the oldest queue entry whose channel is eligible. At most one dispatch per cycle.
  - On a dispatch edge: `vld_ch` = one-hot(ch), `data_gray`/`data_count` = entry fields, entry removed, `occ[ch]` loaded.
  - No dispatch: `vld_ch` = 0; `data_gray`/`data_count` hold their last values.
- Frames for the same channel leave in accept order. The oldest-eligible rule guarantees this, because all entries for a channel share one eligibility bit.
- Same-edge accept and dispatch: dispatch removes the entry first, then the new frame is appended at the tail. `pending` is unchanged. A frame accepted on edge E is first eligible for dispatch on edge E+1.
- No state machine beyond the queue and counters. Each channel is implicitly IDLE (`occ==0`) or SENDING (`occ!=0`).

## Timing
- Reset values: `in_ready`=1 (after reset), `data_gray`=0, `data_count`=0, `vld_ch`=0, `busy_ch`=0, `pending`=0, `err_len`=0. All `occ`=0 and the queue is empty.
- Reset mid-operation: queue contents and counters are discarded immediately. The output stage shares `rst_n`, so both sides restart idle.
- Accept-to-dispatch latency with an idle channel and empty queue is 1 edge:
  - accept at edge E, `vld_ch` high after edge E+1;
  - the output stage latches at E+2, and serial valid spans E+2..E+2+len.
- Same-channel spacing: dispatch edges D1 and D2 satisfy D2 ≥ D1 + len1 + 1. This is exactly the earliest point the serializer is back in IDLE when it samples `vld_ch`.
- Different channels may dispatch on consecutive edges.
- `vld_ch` is never high for two consecutive cycles on the same bit and never has more than one bit set.
- `busy_ch[c]` rises the edge after dispatch and falls when `occ[c]` reaches 0.

## Test plan
- Single frame: ch3, len 16, data 128'hA5… accepted at edge 10 → `vld_ch`=8'h08 for one cycle after edge 11, `data_count`=16, `busy_ch[3]` high for 16 cycles, `pending` back to 0.
- Same channel back-to-back: two ch0 len-8 frames accepted on consecutive edges → second `vld_ch[0]` pulse exactly 9 edges after the first. Order is preserved (payload checked).
- Out-of-order dispatch: queue holds {ch1 len 100, ch1 len 4, ch5 len 4} while ch1 is busy → ch5 dispatches first. The ch1 frames follow in accept order.
- Full queue: ch2 busy with len 128, then 4 frames for ch2 pushed → `in_ready`=0 with `pending`=4. The 5th frame is held by upstream until the first dispatch frees a slot.
- Length errors: `in_len`=0 → `err_len` pulse, `pending` unchanged, no dispatch. `in_len`=200 → `err_len` pulse, dispatched with `data_count`=128.
- Reset mid-send: `rst_n` low during a 64-bit ch7 frame with 2 pending → all outputs 0, `in_ready`=1 after release. A new ch7 frame dispatches 1 edge after accept.

Source files
------------

// File: rtl/output_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : output_dispatch_ctrl
// Purpose  : Age-ordered frame queue that issues each frame to its serializer
//            channel once that channel's tracked occupancy has drained.
// Revision : 1.0  initial release
// ============================================================================
module output_dispatch_ctrl #(
  parameter int DEPTH   = 4,
  parameter int MAX_LEN = 128
) (
  input  logic         clk_out16x,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [2:0]   in_ch,
  input  logic [15:0]  in_len,
  output logic [127:0] data_gray,
  output logic [15:0]  data_count,
  output logic [7:0]   vld_ch,
  output logic [7:0]   busy_ch,
  output logic [3:0]   pending,
  output logic         err_len
);

  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] C_DEPTH   = 4'(DEPTH);
  localparam logic [15:0] C_MAX_LEN = 16'(MAX_LEN);

  logic [127:0]     r_q_data [DEPTH];
  logic [2:0]       r_q_ch   [DEPTH];
  logic [15:0]      r_q_len  [DEPTH];
  logic [3:0]       r_pending;
  logic [7:0][15:0] r_occ;
  logic [127:0]     r_data_gray;
  logic [15:0]      r_data_count;
  logic [7:0]       r_vld_ch;
  logic             r_err_len;

  logic [127:0]     w_n_data [DEPTH];
  logic [2:0]       w_n_ch   [DEPTH];
  logic [15:0]      w_n_len  [DEPTH];
  logic [3:0]       w_n_pending;
  logic [3:0]       w_base;
  logic [7:0]       w_idle;
  logic             w_sel_found;
  logic [IW-1:0]    w_sel_idx;
  logic [2:0]       w_sel_ch;
  logic [15:0]      w_sel_len;
  logic [127:0]     w_sel_data;
  logic             w_accept;
  logic             w_push;
  logic             w_too_long;
  logic [15:0]      w_push_len;

  assign in_ready   = (r_pending != C_DEPTH);
  assign w_accept   = in_valid & in_ready;
  assign w_too_long = (in_len > C_MAX_LEN);
  assign w_push     = w_accept & (in_len != 16'd0);
  assign w_push_len = w_too_long ? C_MAX_LEN : in_len;

  // Oldest valid entry whose channel is idle wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_sel_found && (i < int'(r_pending)) && w_idle[r_q_ch[i]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
      end
    end
  end

  assign w_sel_ch   = r_q_ch[w_sel_idx];
  assign w_sel_len  = r_q_len[w_sel_idx];
  assign w_sel_data = r_q_data[w_sel_idx];

  // Removal compacts the queue first, then the new frame lands at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_n_data[i] = r_q_data[i];
      w_n_ch[i]   = r_q_ch[i];
      w_n_len[i]  = r_q_len[i];
    end
    w_base = r_pending;
    if (w_sel_found) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(w_sel_idx)) begin
          w_n_data[i] = r_q_data[i+1];
          w_n_ch[i]   = r_q_ch[i+1];
          w_n_len[i]  = r_q_len[i+1];
        end
      end
      w_base = r_pending - 4'd1;
    end
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(w_base)) begin
          w_n_data[i] = in_data;
          w_n_ch[i]   = in_ch;
          w_n_len[i]  = w_push_len;
        end
      end
    end
    w_n_pending = w_base + (w_push ? 4'd1 : 4'd0);
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_ch[i]   <= '0;
        r_q_len[i]  <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= w_n_data[i];
        r_q_ch[i]   <= w_n_ch[i];
        r_q_len[i]  <= w_n_len[i];
      end
      r_pending <= w_n_pending;
    end
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_data_gray  <= '0;
      r_data_count <= '0;
      r_vld_ch     <= '0;
      r_err_len    <= 1'b0;
    end else begin
      r_err_len <= w_accept & ((in_len == 16'd0) | w_too_long);
      if (w_sel_found) begin
        r_data_gray  <= w_sel_data;
        r_data_count <= w_sel_len;
        r_vld_ch     <= 8'b1 << w_sel_ch;
      end else begin
        r_vld_ch     <= '0;
      end
    end
  end

  // Occupancy mirrors the serializer: loaded on dispatch, counts down to idle.
  for (genvar c = 0; c < 8; c++) begin : g_occ
    always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) begin
        r_occ[c] <= '0;
      end else if (w_sel_found && (w_sel_ch == 3'(c))) begin
        r_occ[c] <= w_sel_len;
      end else if (r_occ[c] != 16'd0) begin
        r_occ[c] <= r_occ[c] - 16'd1;
      end
    end
    assign w_idle[c]  = (r_occ[c] == 16'd0);
    assign busy_ch[c] = ~w_idle[c];
  end

  assign data_gray  = r_data_gray;
  assign data_count = r_data_count;
  assign vld_ch     = r_vld_ch;
  assign pending    = r_pending;
  assign err_len    = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_output_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_dispatch_ctrl
// Purpose  : Directed and randomized bench against a queue/timestamp model.
// Revision : 1.0  initial release
// ============================================================================
module tb_output_dispatch_ctrl;

  localparam int DEPTH   = 4;
  localparam int MAX_LEN = 128;

  logic         clk_out16x = 1'b0;
  logic         rst_n      = 1'b0;
  logic         in_valid   = 1'b0;
  logic         in_ready;
  logic [127:0] in_data    = '0;
  logic [2:0]   in_ch      = '0;
  logic [15:0]  in_len     = '0;
  logic [127:0] data_gray;
  logic [15:0]  data_count;
  logic [7:0]   vld_ch;
  logic [7:0]   busy_ch;
  logic [3:0]   pending;
  logic         err_len;

  int checks   = 0;
  int failures = 0;

  output_dispatch_ctrl #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk_out16x (clk_out16x),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ch      (in_ch),
    .in_len     (in_len),
    .data_gray  (data_gray),
    .data_count (data_count),
    .vld_ch     (vld_ch),
    .busy_ch    (busy_ch),
    .pending    (pending),
    .err_len    (err_len)
  );

  always #5 clk_out16x = ~clk_out16x;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: frames in an age-ordered queue; each channel is free from a
  // timestamp (dispatch edge + len + 1) onward.
  typedef struct {
    logic [127:0] data;
    logic [2:0]   ch;
    logic [15:0]  len;
  } frame_t;

  frame_t       mq[$];
  longint       t_edge;
  longint       free_at [8];
  logic [7:0]   exp_vld;
  logic [127:0] exp_data;
  logic [15:0]  exp_count;
  logic [7:0]   exp_busy;
  logic         exp_err;

  always @(posedge clk_out16x or negedge rst_n) begin
    int     sel;
    bit     acc;
    frame_t f;
    if (!rst_n) begin
      mq.delete();
      t_edge    = 0;
      for (int c = 0; c < 8; c++) free_at[c] = 0;
      exp_vld   = '0;
      exp_data  = '0;
      exp_count = '0;
      exp_busy  = '0;
      exp_err   = 1'b0;
    end else begin
      t_edge++;
      sel = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (sel < 0 && t_edge >= free_at[mq[i].ch]) sel = i;
      end
      acc     = in_valid && (mq.size() != DEPTH);
      exp_vld = '0;
      exp_err = 1'b0;
      if (sel >= 0) begin
        f         = mq[sel];
        exp_vld   = 8'b1 << f.ch;
        exp_data  = f.data;
        exp_count = f.len;
        free_at[f.ch] = t_edge + longint'(f.len) + 1;
        mq.delete(sel);
      end
      if (acc) begin
        if (in_len == 0) begin
          exp_err = 1'b1;
        end else begin
          f.data = in_data;
          f.ch   = in_ch;
          f.len  = (int'(in_len) > MAX_LEN) ? 16'(MAX_LEN) : in_len;
          if (int'(in_len) > MAX_LEN) exp_err = 1'b1;
          mq.push_back(f);
        end
      end
      for (int c = 0; c < 8; c++) exp_busy[c] = (t_edge < free_at[c] - 1);
    end
  end

  always @(negedge clk_out16x) begin
    if (rst_n) begin
      chk("vld_ch",     128'(vld_ch),     128'(exp_vld));
      chk("data_gray",  data_gray,        exp_data);
      chk("data_count", 128'(data_count), 128'(exp_count));
      chk("busy_ch",    128'(busy_ch),    128'(exp_busy));
      chk("pending",    128'(pending),    128'(mq.size()));
      chk("err_len",    128'(err_len),    128'(exp_err));
      chk("in_ready",   128'(in_ready),   128'(mq.size() != DEPTH));
    end
  end

  // Dispatch log for directed timing/order checks.
  typedef struct {
    int           cyc;
    logic [7:0]   vld;
    logic [15:0]  cnt;
    logic [127:0] data;
  } cap_t;

  cap_t caps[$];
  int   cyc_i = 0;

  task automatic step(input bit v, input logic [127:0] d, input logic [2:0] c, input logic [15:0] l);
    cap_t k;
    in_valid = v; in_data = d; in_ch = c; in_len = l;
    @(negedge clk_out16x);
    cyc_i++;
    if (vld_ch != 0) begin
      k.cyc = cyc_i; k.vld = vld_ch; k.cnt = data_count; k.data = data_gray;
      caps.push_back(k);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pat_a;
    logic [127:0] pat_x;
    logic [127:0] pat_y;
    int           nbusy;
    int           waited;
    bit           was_ready;
    pat_a = {4{32'hA5A5_A5A5}};
    pat_x = {4{32'h1111_2222}};
    pat_y = {4{32'h3333_4444}};

    // Reset values
    repeat (3) @(negedge clk_out16x);
    chk("rst_vld",     128'(vld_ch),     128'(0));
    chk("rst_data",    data_gray,        128'(0));
    chk("rst_count",   128'(data_count), 128'(0));
    chk("rst_busy",    128'(busy_ch),    128'(0));
    chk("rst_pending", 128'(pending),    128'(0));
    chk("rst_err",     128'(err_len),    128'(0));
    chk("rst_ready",   128'(in_ready),   128'(1));
    rst_n = 1'b1;
    idle(5);

    // Single frame, ch3 len16
    caps.delete();
    step(1'b1, pat_a, 3'd3, 16'd16);
    chk("t1_pend_after_acc", 128'(pending), 128'(1));
    chk("t1_vld_at_acc",     128'(vld_ch),  128'(0));
    step(1'b0, '0, '0, '0);
    chk("t1_vld",         128'(vld_ch),     128'(8'h08));
    chk("t1_model_vld",   128'(exp_vld),    128'(8'h08));
    chk("t1_count",       128'(data_count), 128'(16));
    chk("t1_data",        data_gray,        pat_a);
    chk("t1_pend",        128'(pending),    128'(0));
    nbusy = busy_ch[3] ? 1 : 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, '0, '0, '0);
      if (busy_ch[3]) nbusy++;
    end
    chk("t1_busy_cycles", 128'(nbusy),      128'(16));
    chk("t1_single_pulse", 128'(caps.size()), 128'(1));

    // Same channel back-to-back
    caps.delete();
    step(1'b1, pat_x, 3'd0, 16'd8);
    step(1'b1, pat_y, 3'd0, 16'd8);
    idle(20);
    chk("t2_ndisp", 128'(caps.size()), 128'(2));
    if (caps.size() == 2) begin
      chk("t2_spacing", 128'(caps[1].cyc - caps[0].cyc), 128'(9));
      chk("t2_first",   caps[0].data, pat_x);
      chk("t2_second",  caps[1].data, pat_y);
    end

    // Out-of-order dispatch around a busy channel
    caps.delete();
    step(1'b1, 128'h20, 3'd1, 16'd20);
    step(1'b1, 128'h64, 3'd1, 16'd100);
    step(1'b1, 128'h04, 3'd1, 16'd4);
    step(1'b1, 128'h55, 3'd5, 16'd4);
    idle(140);
    chk("t3_ndisp", 128'(caps.size()), 128'(4));
    if (caps.size() == 4) begin
      chk("t3_d0", 128'({caps[0].vld, caps[0].cnt}), 128'({8'h02, 16'd20}));
      chk("t3_d1", 128'({caps[1].vld, caps[1].cnt}), 128'({8'h20, 16'd4}));
      chk("t3_d2", 128'({caps[2].vld, caps[2].cnt}), 128'({8'h02, 16'd100}));
      chk("t3_d3", 128'({caps[3].vld, caps[3].cnt}), 128'({8'h02, 16'd4}));
      chk("t3_gap", 128'(caps[3].cyc - caps[2].cyc), 128'(101));
    end

    // Full queue behind a long ch2 frame
    step(1'b1, 128'hA0, 3'd2, 16'd128);
    for (int i = 1; i <= 4; i++) step(1'b1, 128'(i), 3'd2, 16'd2);
    chk("t4_pending", 128'(pending),  128'(4));
    chk("t4_ready",   128'(in_ready), 128'(0));
    waited = 0;
    in_valid = 1'b1; in_data = 128'h5; in_ch = 3'd2; in_len = 16'd2;
    was_ready = in_ready;
    while (!was_ready && waited < 300) begin
      @(negedge clk_out16x);
      waited++;
      was_ready = in_ready;
    end
    chk("t4_hold_cycles", 128'(waited), 128'(126));
    step(1'b1, 128'h5, 3'd2, 16'd2);
    chk("t4_refill", 128'(pending), 128'(4));
    idle(40);

    // Length errors
    step(1'b1, 128'hDEAD, 3'd4, 16'd0);
    chk("t5_err0",   128'(err_len), 128'(1));
    chk("t5_pend0",  128'(pending), 128'(0));
    step(1'b0, '0, '0, '0);
    chk("t5_nodisp", 128'(vld_ch),  128'(0));
    chk("t5_errclr", 128'(err_len), 128'(0));
    step(1'b1, 128'hBEEF, 3'd6, 16'd200);
    chk("t5_err200", 128'(err_len), 128'(1));
    step(1'b0, '0, '0, '0);
    chk("t5_vld200", 128'(vld_ch),     128'(8'h40));
    chk("t5_clamp",  128'(data_count), 128'(MAX_LEN));
    chk("t5_model_clamp", 128'(exp_count), 128'(MAX_LEN));
    idle(140);

    // Reset in the middle of a ch7 send
    step(1'b1, 128'h77, 3'd7, 16'd64);
    step(1'b1, 128'h78, 3'd7, 16'd8);
    step(1'b1, 128'h79, 3'd7, 16'd8);
    step(1'b0, '0, '0, '0);
    chk("t6_pend_before", 128'(pending), 128'(2));
    rst_n = 1'b0;
    #1;
    chk("t6_vld",   128'(vld_ch),     128'(0));
    chk("t6_data",  data_gray,        128'(0));
    chk("t6_count", 128'(data_count), 128'(0));
    chk("t6_busy",  128'(busy_ch),    128'(0));
    chk("t6_pend",  128'(pending),    128'(0));
    chk("t6_ready", 128'(in_ready),   128'(1));
    @(negedge clk_out16x);
    rst_n = 1'b1;
    step(1'b1, 128'h7A, 3'd7, 16'd5);
    step(1'b0, '0, '0, '0);
    chk("t6_redisp", 128'(vld_ch), 128'(8'h80));
    idle(10);

    // Randomized traffic, one reset in the middle
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] l;
      r = int'($urandom_range(0, 99));
      if (r < 5)       l = 16'd0;
      else if (r < 10) l = 16'($urandom_range(129, 300));
      else             l = 16'($urandom_range(1, 24));
      if (n == 1500) begin
        rst_n = 1'b0;
        @(negedge clk_out16x);
        rst_n = 1'b1;
      end
      step(($urandom_range(0, 9) < 6), {$urandom, $urandom, $urandom, $urandom},
           3'($urandom_range(0, 3)), l);
    end
    idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
